population_mem_arbiter: RTL and testbench

Controller for the GA population memory: sequences the initial fill of all `POPULATION_SIZE` slots, then shares the single write port with the offspring writer and the single read port between two selection readers. It also counts offspring writes into generations. It sits between the population memory (one write port, combinational read port) and the init/selection/crossover engines.

---
 rtl/population_mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_population_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/population_mem_arbiter.sv
// Population memory controller: init sweep, offspring write pass-through,
// round-robin arbitration of two selection readers, and generation counting.
module population_mem_arbiter #(
  parameter int CHROMOSOME_WIDTH = 8,
  parameter int POPULATION_SIZE  = 16,
  parameter int ADDR_WIDTH       = $clog2(POPULATION_SIZE),
  parameter int GEN_WIDTH        = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_init,
  input  logic [CHROMOSOME_WIDTH-1:0] init_data,
  output logic                        init_busy,
  output logic                        init_done,
  input  logic                        wr_req,
  input  logic [ADDR_WIDTH-1:0]       wr_addr,
  input  logic [CHROMOSOME_WIDTH-1:0] wr_data,
  output logic                        wr_gnt,
  input  logic [1:0]                  rd_req,
  input  logic [ADDR_WIDTH-1:0]       rd_addr0,
  input  logic [ADDR_WIDTH-1:0]       rd_addr1,
  output logic [1:0]                  rd_gnt,
  output logic [1:0]                  rd_valid,
  output logic [CHROMOSOME_WIDTH-1:0] rd_data,
  output logic [GEN_WIDTH-1:0]        generation,
  output logic                        gen_done,
  output logic                        mem_write_enable,
  output logic [ADDR_WIDTH-1:0]       mem_write_addr,
  output logic [CHROMOSOME_WIDTH-1:0] mem_write_data,
  output logic [ADDR_WIDTH-1:0]       mem_read_addr,
  input  logic [CHROMOSOME_WIDTH-1:0] mem_read_data
);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN} state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_SLOT = ADDR_WIDTH'(POPULATION_SIZE - 1);

  state_e                      state_q, state_d;
  logic [ADDR_WIDTH-1:0]       init_cnt_q, init_cnt_d;
  logic [ADDR_WIDTH-1:0]       off_cnt_q, off_cnt_d;
  logic [GEN_WIDTH-1:0]        gen_q, gen_d;
  logic                        gen_done_q, gen_done_d;
  logic                        init_done_q, init_done_d;
  logic                        rr_last_q, rr_last_d;   // index of last granted reader
  logic [1:0]                  rd_valid_q;
  logic [CHROMOSOME_WIDTH-1:0] rd_data_q;

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      init_cnt_q  <= '0;
      off_cnt_q   <= '0;
      gen_q       <= '0;
      gen_done_q  <= 1'b0;
      init_done_q <= 1'b0;
      rr_last_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      off_cnt_q   <= off_cnt_d;
      gen_q       <= gen_d;
      gen_done_q  <= gen_done_d;
      init_done_q <= init_done_d;
      rr_last_q   <= rr_last_d;
    end
  end

  // Read result register: captures memory data at the grant edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= '0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_gnt;
      if (|rd_gnt) rd_data_q <= mem_read_data;
    end
  end

  // Next-state, grant and memory-port steering logic.
  always_comb begin
    state_d          = state_q;
    init_cnt_d       = init_cnt_q;
    off_cnt_d        = off_cnt_q;
    gen_d            = gen_q;
    gen_done_d       = 1'b0;
    init_done_d      = 1'b0;
    rr_last_d        = rr_last_q;
    wr_gnt           = 1'b0;
    rd_gnt           = '0;
    mem_write_enable = 1'b0;
    mem_write_addr   = wr_addr;
    mem_write_data   = wr_data;
    mem_read_addr    = rd_addr0;
    unique case (state_q)
      S_IDLE: begin
        if (start_init) begin
          state_d    = S_INIT;
          init_cnt_d = '0;
        end
      end
      S_INIT: begin
        mem_write_enable = 1'b1;
        mem_write_addr   = init_cnt_q;
        mem_write_data   = init_data;
        init_cnt_d       = init_cnt_q + 1'b1;
        if (init_cnt_q == LAST_SLOT) begin
          state_d     = S_RUN;
          init_done_d = 1'b1;
        end
      end
      S_RUN: begin
        if (start_init) begin
          state_d    = S_INIT;
          init_cnt_d = '0;
          off_cnt_d  = '0;
          gen_d      = '0;
        end else begin
          wr_gnt           = wr_req;
          mem_write_enable = wr_req;
          if (wr_req) begin
            if (off_cnt_q == LAST_SLOT) begin
              off_cnt_d  = '0;
              gen_d      = gen_q + 1'b1;
              gen_done_d = 1'b1;
            end else begin
              off_cnt_d = off_cnt_q + 1'b1;
            end
          end
          unique case (rd_req)
            2'b01:   rd_gnt = 2'b01;
            2'b10:   rd_gnt = 2'b10;
            2'b11:   rd_gnt = rr_last_q ? 2'b01 : 2'b10;
            default: rd_gnt = 2'b00;
          endcase
          if (rd_gnt[1]) mem_read_addr = rd_addr1;
          if (|rd_gnt)   rr_last_d     = rd_gnt[1];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign init_busy  = (state_q == S_INIT);
  assign init_done  = init_done_q;
  assign gen_done   = gen_done_q;
  assign generation = gen_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_population_mem_arbiter.sv
// Scoreboard bench for population_mem_arbiter: stimulus pushes expected
// memory writes, read results, generation values and init_done cycles;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_population_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_init;
  logic [7:0] init_data;
  logic       init_busy, init_done;
  logic       wr_req;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_gnt;
  logic [1:0] rd_req;
  logic [3:0] rd_addr0, rd_addr1;
  logic [1:0] rd_gnt, rd_valid;
  logic [7:0] rd_data;
  logic [7:0] generation;
  logic       gen_done;
  logic       mem_write_enable;
  logic [3:0] mem_write_addr;
  logic [7:0] mem_write_data;
  logic [3:0] mem_read_addr;
  logic [7:0] mem_read_data;

  population_mem_arbiter #(
    .CHROMOSOME_WIDTH(8),
    .POPULATION_SIZE (16),
    .GEN_WIDTH       (8)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_init       (start_init),
    .init_data        (init_data),
    .init_busy        (init_busy),
    .init_done        (init_done),
    .wr_req           (wr_req),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .wr_gnt           (wr_gnt),
    .rd_req           (rd_req),
    .rd_addr0         (rd_addr0),
    .rd_addr1         (rd_addr1),
    .rd_gnt           (rd_gnt),
    .rd_valid         (rd_valid),
    .rd_data          (rd_data),
    .generation       (generation),
    .gen_done         (gen_done),
    .mem_write_enable (mem_write_enable),
    .mem_write_addr   (mem_write_addr),
    .mem_write_data   (mem_write_data),
    .mem_read_addr    (mem_read_addr),
    .mem_read_data    (mem_read_data)
  );

  always #5 clk = ~clk;

  // Population memory: one write port, combinational read.
  logic [7:0] mem [16];
  always @(posedge clk) if (mem_write_enable) mem[mem_write_addr] <= mem_write_data;
  assign mem_read_data = mem[mem_read_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  int unsigned wq[$];   // (addr << 8) | data
  int unsigned rq[$];   // (rd_valid << 8) | rd_data
  int unsigned gq[$];   // generation value at gen_done
  int unsigned iq[$];   // cycle index where init_done is expected

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void unexpected(string name, logic [31:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: actual=%0h required=no output (cycle %0d)", name, act, cyc);
  endfunction

  // Monitor: compares every presented output against the scoreboard.
  always @(negedge clk) begin
    if (mem_write_enable) begin
      if (wq.size() == 0) unexpected("mem_write", {mem_write_addr, mem_write_data});
      else check("mem_write", {mem_write_addr, mem_write_data}, wq.pop_front());
    end
    if (|rd_valid) begin
      if (rq.size() == 0) unexpected("rd_result", {rd_valid, rd_data});
      else check("rd_result", {rd_valid, rd_data}, rq.pop_front());
    end
    if (gen_done) begin
      if (gq.size() == 0) unexpected("gen_done", generation);
      else check("generation_at_gen_done", generation, gq.pop_front());
    end
    if (init_done) begin
      if (iq.size() == 0) unexpected("init_done", cyc);
      else check("init_done_cycle", cyc, iq.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_wr(input int unsigned a, input int unsigned d);
    wq.push_back((a << 8) | d);
  endtask

  task automatic exp_rd(input int unsigned v, input int unsigned d);
    rq.push_back((v << 8) | d);
  endtask

  task automatic check_reset();
    check("rst_init_busy", init_busy, 0);
    check("rst_init_done", init_done, 0);
    check("rst_gen_done", gen_done, 0);
    check("rst_generation", generation, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_mem_we", mem_write_enable, 0);
    check("rst_wr_gnt", wr_gnt, 0);
    check("rst_rd_gnt", rd_gnt, 0);
  endtask

  initial begin
    rst_n = 1'b0; start_init = 1'b0; init_data = 8'h00;
    wr_req = 1'b1; wr_addr = 4'd0; wr_data = 8'hA0;
    rd_req = 2'b11; rd_addr0 = 4'd3; rd_addr1 = 4'd7;
    repeat (2) @(posedge clk);
    #1 check_reset();

    // IDLE with requests held: nothing granted.
    step(); rst_n = 1'b1;
    #1 check("idle_wr_gnt", wr_gnt, 0); check("idle_rd_gnt", rd_gnt, 0);

    // Init sweep with requests held and a stray start_init mid-sweep.
    step(); start_init = 1'b1;
    #1 check("start_wr_gnt", wr_gnt, 0); check("start_rd_gnt", rd_gnt, 0);
    iq.push_back(cyc + 17);
    for (int k = 0; k < 16; k++) exp_wr(k, 8'hA0 + k);
    for (int k = 0; k < 16; k++) begin
      step(); start_init = (k == 5); init_data = 8'hA0 + 8'(k);
      #1 check("init_busy", init_busy, 1);
      check("init_wr_gnt", wr_gnt, 0); check("init_rd_gnt", rd_gnt, 0);
    end

    // First RUN cycle: held requests granted; round-robin starts with reader 0.
    step(); start_init = 1'b0;
    #1 check("run1_wr_gnt", wr_gnt, 1); check("run1_rd_gnt", rd_gnt, 2'b01);
    check("run1_init_busy", init_busy, 0);
    exp_wr(0, 8'hA0); exp_rd(2'b01, 8'hA3);
    step(); wr_req = 1'b0;
    #1 check("rr2_rd_gnt", rd_gnt, 2'b10); exp_rd(2'b10, 8'hA7);
    step();
    #1 check("rr3_rd_gnt", rd_gnt, 2'b01); exp_rd(2'b01, 8'hA3);
    step();
    #1 check("rr4_rd_gnt", rd_gnt, 2'b10); exp_rd(2'b10, 8'hA7);

    // Read/write collision on slot 4: old value returned, new one next read.
    step(); wr_req = 1'b1; wr_addr = 4'd4; wr_data = 8'h55; rd_req = 2'b01; rd_addr0 = 4'd4;
    #1 check("coll_wr_gnt", wr_gnt, 1); check("coll_rd_gnt", rd_gnt, 2'b01);
    check("coll_rd_addr", mem_read_addr, 4);
    exp_wr(4, 8'h55); exp_rd(2'b01, 8'hA4);
    step(); wr_req = 1'b0;
    #1 exp_rd(2'b01, 8'h55);
    // Lone reader 1 is granted regardless of the pointer.
    step(); rd_req = 2'b10;
    #1 check("solo1a_rd_gnt", rd_gnt, 2'b10); check("solo1a_rd_addr", mem_read_addr, 7);
    exp_rd(2'b10, 8'hA7);
    step();
    #1 check("solo1b_rd_gnt", rd_gnt, 2'b10); exp_rd(2'b10, 8'hA7);
    step(); rd_req = 2'b00;

    // Generation count: two writes so far, 14 more completes generation 1.
    for (int k = 0; k < 14; k++) begin
      step(); wr_req = 1'b1; wr_addr = 4'(k); wr_data = 8'h10 + 8'(k);
      exp_wr(k, 8'h10 + k);
      #1 check("gen1_wr_gnt", wr_gnt, 1);
      check("gen1_pending", gen_done, 0);
    end
    gq.push_back(1);
    step(); wr_req = 1'b0;
    #1 check("gen1_generation", generation, 1); check("gen1_gen_done", gen_done, 1);
    for (int k = 0; k < 16; k++) begin
      step(); wr_req = 1'b1; wr_addr = 4'(15 - k); wr_data = 8'h30 + 8'(k);
      exp_wr(15 - k, 8'h30 + k);
    end
    gq.push_back(2);
    step(); wr_req = 1'b0;
    #1 check("gen2_generation", generation, 2);

    // Restart from RUN with requests pending: no grants, generation cleared.
    step(); start_init = 1'b1; wr_req = 1'b1; rd_req = 2'b11;
    #1 check("restart_wr_gnt", wr_gnt, 0); check("restart_rd_gnt", rd_gnt, 0);
    for (int k = 0; k < 10; k++) exp_wr(k, 8'hC0 + k);
    for (int k = 0; k < 10; k++) begin
      step(); start_init = 1'b0; wr_req = 1'b0; rd_req = 2'b00; init_data = 8'hC0 + 8'(k);
      #1 if (k == 0) check("restart_generation", generation, 0);
      check("restart_init_busy", init_busy, 1);
    end

    // Asynchronous reset while slot 9 is being written.
    @(negedge clk); #1 rst_n = 1'b0;
    #1 check_reset();
    step(); step();
    check("rst_hold_init_busy", init_busy, 0);
    rst_n = 1'b1;

    // Fresh init sweep restarts at address 0.
    step(); start_init = 1'b1;
    iq.push_back(cyc + 17);
    for (int k = 0; k < 16; k++) exp_wr(k, 8'hD0 + k);
    for (int k = 0; k < 16; k++) begin
      step(); start_init = 1'b0; init_data = 8'hD0 + 8'(k);
      #1 if (k == 0) check("reinit_first_addr", mem_write_addr, 0);
    end
    step();
    #1 check("reinit_init_busy", init_busy, 0); check("reinit_generation", generation, 0);
    rd_req = 2'b01; rd_addr0 = 4'd9;
    #1 check("reinit_rd_gnt", rd_gnt, 2'b01); exp_rd(2'b01, 8'hD9);
    step(); rd_req = 2'b00;
    repeat (3) step();

    check("wq_drained", wq.size(), 0);
    check("rq_drained", rq.size(), 0);
    check("gq_drained", gq.size(), 0);
    check("iq_drained", iq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
